// File: rtl/obstacle_follower_lane_pkg.sv
// Shared lane definitions: screen geometry, scroll step, lane FSM states
// and the half-open box overlap helper used by every car box test.
package obstacle_follower_lane_pkg;

  localparam int SCREEN_W = 640;
  localparam int MOVE_AMT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPAWN = 2'd1,
    RUN   = 2'd2
  } lane_state_t;

  // Two half-open intervals [a0,a1) and [b0,b1) overlap when each one
  // starts before the other ends; touching ends are not an overlap.
  function automatic logic box_overlap(input logic [10:0] a0,
                                       input logic [10:0] a1,
                                       input logic [10:0] b0,
                                       input logic [10:0] b1);
    return (a0 < b1) && (b0 < a1);
  endfunction

endpackage

// File: rtl/obstacle_follower_lane_if.sv
// Scroll/VGA/chicken bundle between the lane scroller side and the
// follower lane. The master drives positions and strobes; the slave
// (the follower lane) returns follower flags, pixel-on and hit.
interface obstacle_follower_lane_if #(
  parameter int NUM_FOL = 3
) ();

  logic               move_strobe;
  logic [9:0]         lead_pos;
  logic [9:0]         pix_x;
  logic [9:0]         pix_y;
  logic [9:0]         chick_x;
  logic [9:0]         chick_y;
  logic               hit_clr;
  logic [NUM_FOL-1:0] fol_active;
  logic               pix_on;
  logic               hit;

  modport master (
    output move_strobe, lead_pos, pix_x, pix_y, chick_x, chick_y, hit_clr,
    input  fol_active, pix_on, hit
  );

  modport slave (
    input  move_strobe, lead_pos, pix_x, pix_y, chick_x, chick_y, hit_clr,
    output fol_active, pix_on, hit
  );

endinterface

// File: rtl/obstacle_follower_lane_car_box_hit.sv
// Combinational test of one lane car against two probe boxes: the
// current VGA pixel and the chicken square. The car box is clipped at
// the right screen edge rather than wrapped to column 0.
module obstacle_follower_lane_car_box_hit #(
  parameter int CAR_W    = 32,
  parameter int CAR_H    = 16,
  parameter int LANE_Y   = 200,
  parameter int SCREEN_W = obstacle_follower_lane_pkg::SCREEN_W
) (
  input  logic        en,
  input  logic [9:0]  car_x,
  input  logic [10:0] pix_x0,
  input  logic [10:0] pix_x1,
  input  logic [10:0] pix_y0,
  input  logic [10:0] pix_y1,
  input  logic [10:0] chk_x0,
  input  logic [10:0] chk_x1,
  input  logic [10:0] chk_y0,
  input  logic [10:0] chk_y1,
  output logic        pix_hit,
  output logic        chk_hit
);
  import obstacle_follower_lane_pkg::*;

  localparam logic [10:0] LANE_TOP = 11'(LANE_Y);
  localparam logic [10:0] LANE_BOT = 11'(LANE_Y + CAR_H);

  logic [10:0] car_x0;
  logic [10:0] car_end;
  logic [10:0] car_x1;

  // Build the clipped car box and test both probes against it.
  always_comb begin
    car_x0  = {1'b0, car_x};
    car_end = car_x0 + 11'(CAR_W);
    car_x1  = (car_end > 11'(SCREEN_W)) ? 11'(SCREEN_W) : car_end;
    pix_hit = en && box_overlap(pix_x0, pix_x1, car_x0, car_x1)
                 && box_overlap(pix_y0, pix_y1, LANE_TOP, LANE_BOT);
    chk_hit = en && box_overlap(chk_x0, chk_x1, car_x0, car_x1)
                 && box_overlap(chk_y0, chk_y1, LANE_TOP, LANE_BOT);
  end

endmodule

// File: rtl/obstacle_follower_lane.sv
// Follower lane: spawns NUM_FOL cars at fixed gaps behind the scrolled
// leader, moves them in lock-step on each scroller strobe with the same
// screen-width wrap as the leader, and produces registered pixel-on and
// chicken-hit outputs.
// Optional feature macro: OBSTACLE_HIT_LATCH_EN makes hit sticky until
// hit_clr is seen in a cycle without overlap (overlap wins over clear).
module obstacle_follower_lane #(
  parameter int NUM_FOL  = 3,
  parameter int GAP      = 160,
  parameter int MOVE_AMT = obstacle_follower_lane_pkg::MOVE_AMT,
  parameter int SCREEN_W = obstacle_follower_lane_pkg::SCREEN_W,
  parameter int LANE_Y   = 200,
  parameter int CAR_W    = 32,
  parameter int CAR_H    = 16,
  parameter int CHICK_SZ = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  obstacle_follower_lane_if.slave bus
);
  import obstacle_follower_lane_pkg::*;

  localparam int                 NUM_CAR  = NUM_FOL + 1;
  localparam int                 IDX_W    = 3;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_FOL - 1);

  lane_state_t        state, state_nxt;
  logic [9:0]         fol_pos     [NUM_FOL];
  logic [9:0]         fol_pos_nxt [NUM_FOL];
  logic [NUM_FOL-1:0] fol_active, fol_active_nxt;
  logic [IDX_W-1:0]   next_idx, next_idx_nxt;
  logic [10:0]        spawn_thr;

  logic [9:0]         car_x [NUM_CAR];
  logic [NUM_CAR-1:0] car_en;
  logic [NUM_CAR-1:0] pix_hit;
  logic [NUM_CAR-1:0] chk_hit;
  logic [10:0]        pix_x0, pix_x1, pix_y0, pix_y1;
  logic [10:0]        chk_x0, chk_x1, chk_y0, chk_y1;
  logic               pix_any_p0, chk_any_p0;
  logic               pix_on_p1, hit_p1;

  // One scroll step with the same wrap rule the leader uses; the sum is
  // formed in 11 bits so 638+2 cannot alias below the limit.
  function automatic logic [9:0] step_wrap(input logic [9:0] pos);
    logic [10:0] sum;
    sum = {1'b0, pos} + 11'(MOVE_AMT);
    return (sum >= 11'(SCREEN_W)) ? 10'd0 : sum[9:0];
  endfunction

  // Next-state logic: spawn one follower per strobe until all are out,
  // and advance every active follower on each strobe.
  always_comb begin
    state_nxt      = state;
    fol_pos_nxt    = fol_pos;
    fol_active_nxt = fol_active;
    next_idx_nxt   = next_idx;
    spawn_thr      = ({8'd0, next_idx} + 11'd1) * 11'(GAP);
    if (bus.move_strobe) begin
      case (state)
        IDLE: begin
          state_nxt = SPAWN;
        end
        SPAWN: begin
          for (int k = 0; k < NUM_FOL; k++) begin
            if (fol_active[k]) fol_pos_nxt[k] = step_wrap(fol_pos[k]);
          end
          if ({1'b0, bus.lead_pos} >= spawn_thr) begin
            for (int k = 0; k < NUM_FOL; k++) begin
              if (next_idx == IDX_W'(k)) begin
                fol_active_nxt[k] = 1'b1;
                fol_pos_nxt[k]    = bus.lead_pos - spawn_thr[9:0];
              end
            end
            next_idx_nxt = next_idx + 3'd1;
            if (next_idx == LAST_IDX) state_nxt = RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NUM_FOL; k++) begin
            if (fol_active[k]) fol_pos_nxt[k] = step_wrap(fol_pos[k]);
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // FSM and follower state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      fol_active <= '0;
      next_idx   <= '0;
      for (int k = 0; k < NUM_FOL; k++) fol_pos[k] <= '0;
    end else begin
      state      <= state_nxt;
      fol_active <= fol_active_nxt;
      next_idx   <= next_idx_nxt;
      for (int k = 0; k < NUM_FOL; k++) fol_pos[k] <= fol_pos_nxt[k];
    end
  end

  // Car list (leader first, always present) and the two probe boxes.
  always_comb begin
    car_x[0]  = bus.lead_pos;
    car_en[0] = 1'b1;
    for (int k = 0; k < NUM_FOL; k++) begin
      car_x[k+1]  = fol_pos[k];
      car_en[k+1] = fol_active[k];
    end
    pix_x0 = {1'b0, bus.pix_x};
    pix_x1 = pix_x0 + 11'd1;
    pix_y0 = {1'b0, bus.pix_y};
    pix_y1 = pix_y0 + 11'd1;
    chk_x0 = {1'b0, bus.chick_x};
    chk_x1 = chk_x0 + 11'(CHICK_SZ);
    chk_y0 = {1'b0, bus.chick_y};
    chk_y1 = chk_y0 + 11'(CHICK_SZ);
  end

  for (genvar c = 0; c < NUM_CAR; c++) begin : g_car
    obstacle_follower_lane_car_box_hit #(
      .CAR_W    (CAR_W),
      .CAR_H    (CAR_H),
      .LANE_Y   (LANE_Y),
      .SCREEN_W (SCREEN_W)
    ) u_car_box_hit (
      .en      (car_en[c]),
      .car_x   (car_x[c]),
      .pix_x0  (pix_x0),
      .pix_x1  (pix_x1),
      .pix_y0  (pix_y0),
      .pix_y1  (pix_y1),
      .chk_x0  (chk_x0),
      .chk_x1  (chk_x1),
      .chk_y0  (chk_y0),
      .chk_y1  (chk_y1),
      .pix_hit (pix_hit[c]),
      .chk_hit (chk_hit[c])
    );
  end

  assign pix_any_p0 = |pix_hit;
  assign chk_any_p0 = |chk_hit;

`ifndef OBSTACLE_HIT_LATCH_EN
  logic unused_hit_clr;
  assign unused_hit_clr = bus.hit_clr;
`endif

  // Output register stage: pixel-on and (optionally sticky) hit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_on_p1 <= 1'b0;
      hit_p1    <= 1'b0;
    end else begin
      pix_on_p1 <= pix_any_p0;
`ifdef OBSTACLE_HIT_LATCH_EN
      hit_p1    <= chk_any_p0 | (hit_p1 & ~bus.hit_clr);
`else
      hit_p1    <= chk_any_p0;
`endif
    end
  end

  assign bus.fol_active = fol_active;
  assign bus.pix_on     = pix_on_p1;
  assign bus.hit        = hit_p1;

endmodule

// File: tb/tb_obstacle_follower_lane.sv
// Scoreboard bench for obstacle_follower_lane: the driver pushes the
// hand-computed expected {fol_active, pix_on, hit} for each checked
// cycle; a monitor pops one entry per flagged output cycle.
module tb_obstacle_follower_lane;

  localparam int NUM_FOL = 3;
`ifdef OBSTACLE_HIT_LATCH_EN
  localparam logic LATCH = 1'b1;
`else
  localparam logic LATCH = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  obstacle_follower_lane_if #(.NUM_FOL(NUM_FOL)) bus ();

  obstacle_follower_lane #(.NUM_FOL(NUM_FOL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  string      name_q[$];
  logic [4:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       chk_req = 1'b0;
  logic       chk_vld = 1'b0;

  logic [9:0] lead = 10'd100;
  logic [9:0] px = 10'd0, py = 10'd0, cx = 10'd600, cy = 10'd0;
  logic       clr = 1'b1, rst_v = 1'b0;

  always @(posedge clk) chk_vld <= chk_req;

  always @(negedge clk) begin
    logic [4:0] e;
    string      nm;
    if (chk_vld) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: got act=%b pix=%b hit=%b, no entry queued",
                 bus.fol_active, bus.pix_on, bus.hit);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if ({bus.fol_active, bus.pix_on, bus.hit} !== e) begin
          n_bad++;
          $display("FAIL %s: got act=%b pix=%b hit=%b, want act=%b pix=%b hit=%b",
                   nm, bus.fol_active, bus.pix_on, bus.hit, e[4:2], e[1], e[0]);
        end
      end
    end
  end

  task automatic cyc(input string nm, input logic stb, input logic [2:0] act,
                     input logic p, input logic h);
    @(negedge clk);
    rst_n           = rst_v;
    bus.move_strobe = stb;
    bus.lead_pos    = lead;
    bus.pix_x       = px;
    bus.pix_y       = py;
    bus.chick_x     = cx;
    bus.chick_y     = cy;
    bus.hit_clr     = clr;
    chk_req         = 1'b1;
    name_q.push_back(nm);
    exp_q.push_back({act, p, h});
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.move_strobe = 1'b0;
      chk_req         = 1'b0;
    end
  endtask

  task automatic probe_pix(input string nm, input logic [9:0] x, input logic [9:0] y,
                           input logic [2:0] act, input logic p);
    px = x; py = y;
    cyc(nm, 1'b0, act, p, 1'b0);
    px = 10'd0; py = 10'd0;
  endtask

  task automatic probe_hit(input string nm, input logic [9:0] x, input logic [9:0] y,
                           input logic [2:0] act, input logic h);
    cx = x; cy = y;
    cyc(nm, 1'b0, act, 1'b0, h);
    cx = 10'd600; cy = 10'd0;
  endtask

  function automatic logic [2:0] spawn_act(input int v);
    if (v >= 480) return 3'b111;
    if (v >= 320) return 3'b011;
    if (v >= 160) return 3'b001;
    return 3'b000;
  endfunction

  initial begin
    bus.move_strobe = 1'b0; bus.lead_pos = 10'd100;
    bus.pix_x = 10'd0; bus.pix_y = 10'd0;
    bus.chick_x = 10'd600; bus.chick_y = 10'd0; bus.hit_clr = 1'b1;

    // Reset held with strobes and a pixel/chicken inside the leader.
    rst_v = 1'b0; px = 10'd100; py = 10'd200; cx = 10'd110; cy = 10'd205;
    for (int i = 0; i < 5; i++) cyc("reset", 1'b1, 3'b000, 1'b0, 1'b0);
    rst_v = 1'b1; px = 10'd0; py = 10'd0; cx = 10'd600; cy = 10'd0;

    // Leader only, at x=100, in IDLE.
    probe_pix("pix_in",        10'd100, 10'd200, 3'b000, 1'b1);
    probe_pix("pix_last_col",  10'd131, 10'd200, 3'b000, 1'b1);
    probe_pix("pix_right_out", 10'd132, 10'd200, 3'b000, 1'b0);
    probe_pix("pix_left_out",  10'd99,  10'd200, 3'b000, 1'b0);
    probe_pix("pix_below",     10'd100, 10'd216, 3'b000, 1'b0);
    probe_pix("pix_last_row",  10'd100, 10'd215, 3'b000, 1'b1);
    probe_pix("pix_above",     10'd100, 10'd199, 3'b000, 1'b0);
    probe_hit("hit_in",        10'd110, 10'd205, 3'b000, 1'b1);
    probe_hit("hit_touch_r",   10'd132, 10'd205, 3'b000, 1'b0);
    probe_hit("hit_touch_l",   10'd84,  10'd205, 3'b000, 1'b0);
    probe_hit("hit_over_l",    10'd85,  10'd205, 3'b000, 1'b1);
    probe_hit("hit_touch_top", 10'd110, 10'd184, 3'b000, 1'b0);
    probe_hit("hit_over_top",  10'd110, 10'd185, 3'b000, 1'b1);
    probe_hit("hit_touch_bot", 10'd110, 10'd216, 3'b000, 1'b0);

    // Spawn sequence with back-to-back strobes.
    for (int v = 2; v <= 480; v += 2) begin
      lead = 10'(v);
      cyc("spawn", 1'b1, spawn_act(v), 1'b0, 1'b0);
    end

    // Lead 480: followers at 320, 160, 0.
    probe_pix("run_f0_start",  10'd320, 10'd200, 3'b111, 1'b1);
    probe_pix("run_f0_before", 10'd319, 10'd200, 3'b111, 1'b0);
    probe_pix("run_f0_end",    10'd351, 10'd200, 3'b111, 1'b1);
    probe_pix("run_f0_after",  10'd352, 10'd200, 3'b111, 1'b0);
    probe_pix("run_f1_start",  10'd160, 10'd200, 3'b111, 1'b1);
    probe_pix("run_f1_after",  10'd192, 10'd200, 3'b111, 1'b0);
    probe_pix("run_f2_start",  10'd0,   10'd200, 3'b111, 1'b1);
    probe_pix("run_f2_end",    10'd31,  10'd200, 3'b111, 1'b1);
    probe_pix("run_f2_after",  10'd32,  10'd200, 3'b111, 1'b0);
    probe_pix("run_lead_end",  10'd511, 10'd200, 3'b111, 1'b1);
    probe_pix("run_lead_after",10'd512, 10'd200, 3'b111, 1'b0);

    // Scroll through the leader wrap until lead = 158 (follower 0 at 638).
    while (lead != 10'd158) begin
      lead = (lead + 10'd2 >= 10'd640) ? 10'd0 : lead + 10'd2;
      cyc("scroll", 1'b1, 3'b111, 1'b0, 1'b0);
    end
    probe_pix("clip_638",      10'd638, 10'd200, 3'b111, 1'b1);
    probe_pix("clip_639",      10'd639, 10'd200, 3'b111, 1'b1);
    probe_pix("clip_637",      10'd637, 10'd200, 3'b111, 1'b0);
    probe_pix("clip_no_wrap",  10'd0,   10'd200, 3'b111, 1'b0);
    probe_hit("clip_hit",      10'd630, 10'd205, 3'b111, 1'b1);
    probe_hit("clip_hit_col0", 10'd0,   10'd205, 3'b111, 1'b0);

    // One strobe: follower 0 wraps 638 -> 0.
    lead = 10'd160;
    cyc("wrap_strobe", 1'b1, 3'b111, 1'b0, 1'b0);
    probe_pix("wrap_f0_col0",  10'd0,   10'd200, 3'b111, 1'b1);
    probe_pix("wrap_f0_old",   10'd638, 10'd200, 3'b111, 1'b0);

    // Long idle without strobes: nothing moves.
    quiet(1000);
    probe_pix("hold_f0",       10'd0,   10'd200, 3'b111, 1'b1);
    probe_pix("hold_f0_after", 10'd32,  10'd200, 3'b111, 1'b0);
    probe_pix("hold_lead",     10'd160, 10'd200, 3'b111, 1'b1);
    probe_pix("hold_f2",       10'd320, 10'd200, 3'b111, 1'b1);
    probe_pix("hold_f1",       10'd480, 10'd200, 3'b111, 1'b1);
    probe_pix("hold_f1_before",10'd479, 10'd200, 3'b111, 1'b0);

    // Hit behaviour with and without clear (leader at 160).
    clr = 1'b0; cx = 10'd170; cy = 10'd205;
    cyc("hit_set", 1'b0, 3'b111, 1'b0, 1'b1);
    clr = 1'b1;
    cyc("hit_set_wins", 1'b0, 3'b111, 1'b0, 1'b1);
    clr = 1'b0; cx = 10'd600; cy = 10'd0;
    cyc("hit_away", 1'b0, 3'b111, 1'b0, LATCH);
    cyc("hit_away_hold", 1'b0, 3'b111, 1'b0, LATCH);
    clr = 1'b1;
    cyc("hit_cleared", 1'b0, 3'b111, 1'b0, 1'b0);
    clr = 1'b0;
    cyc("hit_stays_clr", 1'b0, 3'b111, 1'b0, 1'b0);
    clr = 1'b1;

    // Reset, respawn two followers, then reset mid-spawn.
    rst_v = 1'b0;
    cyc("reset_run", 1'b1, 3'b000, 1'b0, 1'b0);
    rst_v = 1'b1;
    for (int v = 2; v <= 330; v += 2) begin
      lead = 10'(v);
      cyc("respawn", 1'b1, spawn_act(v), 1'b0, 1'b0);
    end
    rst_v = 1'b0;
    cyc("reset_mid", 1'b1, 3'b000, 1'b0, 1'b0);
    cyc("reset_mid", 1'b1, 3'b000, 1'b0, 1'b0);
    rst_v = 1'b1;
    lead = 10'd332; cyc("restart_idle", 1'b1, 3'b000, 1'b0, 1'b0);
    lead = 10'd334; cyc("restart_f0",   1'b1, 3'b001, 1'b0, 1'b0);
    lead = 10'd336; cyc("restart_f1",   1'b1, 3'b011, 1'b0, 1'b0);
    probe_pix("re_f0_start",   10'd176, 10'd200, 3'b011, 1'b1);
    probe_pix("re_f0_before",  10'd175, 10'd200, 3'b011, 1'b0);
    probe_pix("re_f1_start",   10'd16,  10'd200, 3'b011, 1'b1);
    probe_pix("re_f1_before",  10'd15,  10'd200, 3'b011, 1'b0);
    probe_pix("re_f1_after",   10'd48,  10'd200, 3'b011, 1'b0);
    lead = 10'd338; cyc("restart_no_f2", 1'b1, 3'b011, 1'b0, 1'b0);
    probe_pix("re_f0_moved",   10'd178, 10'd200, 3'b011, 1'b1);
    probe_pix("re_f0_old",     10'd177, 10'd200, 3'b011, 1'b0);

    quiet(1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
